vram_arbiter: RTL

- Shares the single read/write port A of the dual-port video RAM between two requesters.
  - CPU side: via the SoC bus.
  - Hardware side: a fill/clear DMA engine.
- Port B stays dedicated to VGA scan-out and is not touched by this block.
- Registers all VRAM port-A controls, arbitrates per access, and returns read data after the 1-cycle BRAM latency with a valid pulse.
- Sits between the bus / DMA engine and the vram instance, replacing the direct bus-to-vram wiring.

---
 rtl/vram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates VRAM port A between the CPU bus and the fill/clear DMA engine.
// Optional VRAM_ARB_CPU_PRIO_EN: CPU always wins a tie instead of round-robin.
module vram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              mclk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE_CPU = 2'd1,
    ST_ISSUE_DMA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_dma_q, last_dma_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                dma_gnt_q, dma_gnt_d;
  logic                vram_we_q, vram_we_d;
  logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0]   vram_din_q, vram_din_d;
  logic                tag_a_vld_q, tag_a_vld_d;
  logic                tag_a_dma_q, tag_a_dma_d;
  logic                tag_b_vld_q, tag_b_vld_d;
  logic                tag_b_dma_q, tag_b_dma_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                busy_q, busy_d;
  logic                cpu_elig, dma_elig;

  // Arbitration, issue register load and read-return routing
  always_comb begin
    state_d      = ST_IDLE;
    last_dma_d   = last_dma_q;
    cpu_gnt_d    = 1'b0;
    dma_gnt_d    = 1'b0;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_din_d   = vram_din_q;
    tag_a_vld_d  = 1'b0;
    tag_a_dma_d  = 1'b0;
    tag_b_vld_d  = tag_a_vld_q;
    tag_b_dma_d  = tag_a_dma_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rvalid_d = 1'b0;
    dma_rdata_d  = dma_rdata_q;

    // A requester being granted this cycle must not be issued twice
    cpu_elig = cpu_req && (state_q != ST_ISSUE_CPU);
    dma_elig = dma_req && (state_q != ST_ISSUE_DMA);

    if (cpu_elig && dma_elig) begin
`ifdef VRAM_ARB_CPU_PRIO_EN
      state_d = ST_ISSUE_CPU;
`else
      state_d = last_dma_q ? ST_ISSUE_CPU : ST_ISSUE_DMA;
`endif
    end else if (cpu_elig) begin
      state_d = ST_ISSUE_CPU;
    end else if (dma_elig) begin
      state_d = ST_ISSUE_DMA;
    end

    case (state_d)
      ST_ISSUE_CPU: begin
        cpu_gnt_d   = 1'b1;
        last_dma_d  = 1'b0;
        vram_we_d   = cpu_we;
        vram_addr_d = cpu_addr;
        vram_din_d  = cpu_wdata;
        tag_a_vld_d = ~cpu_we;
      end
      ST_ISSUE_DMA: begin
        dma_gnt_d   = 1'b1;
        last_dma_d  = 1'b1;
        vram_we_d   = dma_we;
        vram_addr_d = dma_addr;
        vram_din_d  = dma_wdata;
        tag_a_vld_d = ~dma_we;
        tag_a_dma_d = 1'b1;
      end
      default: ;
    endcase

    // BRAM output is valid while the second tag stage is occupied
    if (tag_b_vld_q) begin
      if (tag_b_dma_q) begin
        dma_rvalid_d = 1'b1;
        dma_rdata_d  = vram_dout;
      end else begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = vram_dout;
      end
    end

    busy_d = (state_d != ST_IDLE) || tag_a_vld_d || tag_b_vld_d;
  end

  always_ff @(posedge mclk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      last_dma_q   <= 1'b1;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_din_q   <= '0;
      tag_a_vld_q  <= 1'b0;
      tag_a_dma_q  <= 1'b0;
      tag_b_vld_q  <= 1'b0;
      tag_b_dma_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dma_q   <= last_dma_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_din_q   <= vram_din_d;
      tag_a_vld_q  <= tag_a_vld_d;
      tag_a_dma_q  <= tag_a_dma_d;
      tag_b_vld_q  <= tag_b_vld_d;
      tag_b_dma_q  <= tag_b_dma_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dma_gnt    = dma_gnt_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_din   = vram_din_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;
  assign busy       = busy_q;

endmodule
